// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - GCD operand/result datapath with load and result handshakes
// Optional GCD_DP_ZERO_GUARD_EN: a zero operand skips RUN and resolves to A|B directly.
module gcd_datapath #(
  parameter int BusSize = 8,
  parameter int CntW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BusSize-1:0] A_in_i,
  input  logic [BusSize-1:0] B_in_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BusSize-1:0] A_o,
  output logic [BusSize-1:0] B_o,
  output logic               go_o,
  input  logic [1:0]         A_op_i,
  input  logic [1:0]         B_op_i,
  input  logic               done_i,
  output logic [BusSize-1:0] result_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic               busy_o,
  output logic [CntW-1:0]    cycles_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BusSize-1:0] a_q, b_q, result_q;
  logic [BusSize-1:0] a_next, b_next;
  logic [CntW-1:0]    cycles_q;
  logic               zero_load;

`ifdef GCD_DP_ZERO_GUARD_EN
  assign zero_load = (A_in_i == '0) || (B_in_i == '0);
`else
  assign zero_load = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    go_o        = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = zero_load ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        go_o   = 1'b1;
        busy_o = 1'b1;
        if (done_i) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        res_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Both next values read only pre-edge registers, so A=B with B=A is a true swap.
  always_comb begin
    a_next = a_q;
    b_next = b_q;
    case (A_op_i)
      2'b00:   a_next = a_q - b_q;
      2'b01:   a_next = A_in_i;
      2'b10:   a_next = b_q;
      default: a_next = a_q;
    endcase
    case (B_op_i)
      2'b00:   b_next = B_in_i;
      2'b01:   b_next = a_q;
      default: b_next = b_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_q      <= A_in_i;
            b_q      <= B_in_i;
            cycles_q <= '0;
            if (zero_load) begin
              result_q <= A_in_i | B_in_i;
            end
          end
        end
        S_RUN: begin
          if (cycles_q != '1) begin
            cycles_q <= cycles_q + CntW'(1);
          end
          if (done_i) begin
            result_q <= a_q;
          end else begin
            a_q <= a_next;
            b_q <= b_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign A_o      = a_q;
  assign B_o      = b_q;
  assign result_o = result_q;
  assign cycles_o = cycles_q;

endmodule
